run_sequencer: RTL and testbench
================================

# run_sequencer

Host-facing run controller for the multiprocessor core. It owns the instruction memory, accepts a program from the host over a valid/ready stream, and resets the core's control/PC state through a one-cycle clear. It then gates `global_enable` while the core executes, and ends the run on program fall-through, cycle budget exhaustion or host stop. It sits between the host and the `control`/`multiprocessor` pair, driving their `instruction`, `rst` and `global_enable` inputs.

## Interface
- `INSTR_WIDTH`, 32, instruction word width (matches `instruction_t`).
- `PC_WIDTH`, 10, program counter width (matches `pc_t`); memory depth = 2**PC_WIDTH.
- `CYCLE_WIDTH`, 32, budget and cycle counter width.

- `clk` in 1: single clock; everything is synchronous to the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: host program word valid.
- `load_ready` out 1: word accepted when `load_valid && load_ready`.
- `load_data` in INSTR_WIDTH: program word.
- `load_last` in 1: final word of the program.
- `start` in 1: begin run (level sampled).
- `stop` in 1: abort run.
- `budget` in CYCLE_WIDTH: max enabled cycles, latched at start; 0 = unlimited.
- `program_counter` in PC_WIDTH: core PC.
- `instruction` out INSTR_WIDTH: instruction fetched for the core.
- `core_rst` out 1: reset to core.
- `global_enable` out 1: core execute enable.
- `busy` out 1: CLEAR or RUN.
- `done` out 1: one-cycle end-of-run pulse.
- `timed_out` out 1: last run ended on budget.
- `stopped` out 1: last run ended on `stop`.
- `cycles_run` out CYCLE_WIDTH: enabled cycles in last/current run.

## Operation
- State machine: IDLE, CLEAR, RUN, DONE. Reset → IDLE.
- Loading:
  - IDLE only, `load_ready` = 1 in IDLE, else 0.
  - An accepted word writes `mem[wptr]`, then `wptr++`.
  - If `load_last` is set, or `wptr == 2**PC_WIDTH-1`, then `prog_len <= wptr+1` and `wptr <= 0`. A full memory therefore forces last.
  - `prog_len` keeps the previous program until a new last word lands.
- Start:
  - Honoured in IDLE only when `wptr == 0`, no handshake is occurring that cycle, and `prog_len != 0`. Otherwise it is ignored, so a load wins over a simultaneous start.
  - On start: latch `budget`, clear `cycles_run`, `timed_out`, `stopped` → CLEAR.
- CLEAR: exactly 1 cycle; `core_rst` = 1, `global_enable` = 0 → RUN.
- RUN:
  - `global_enable = (program_counter < prog_len)`.
  - `instruction = mem[program_counter]` when in range, else all-zero.
  - `cycles_run` increments on every cycle with `global_enable` = 1, saturating at all-ones.
  - Exit priority:
    1. `stop` → DONE, `stopped` = 1; the enable is still driven that cycle.
    2. `program_counter >= prog_len` (halt) → DONE.
    3. The enabled cycle that brings `cycles_run` to the latched budget (budget ≠ 0) → DONE, `timed_out` = 1.
- DONE: 1 cycle, `done` = 1, `global_enable` = 0 → IDLE. Status outputs hold until the next accepted start.
- `stop` outside RUN: ignored.
- `instruction` outside RUN: still `mem[program_counter]`/zero rule (combinational read); harmless because enable = 0.
- `busy` = state ∈ {CLEAR, RUN}.

## Timing
- Reset values:
  - State IDLE; `wptr` = 0, `prog_len` = 0, `cycles_run` = 0.
  - `done` = 0, `timed_out` = 0, `stopped` = 0, `global_enable` = 0, `load_ready` = 1 after reset.
  - `core_rst` = 1 while `rst` is high (`core_rst = rst | state==CLEAR`).
  - Memory contents are not reset.
- Memory write visible to a read the cycle after acceptance. Read path is combinational (PC → instruction, zero latency).
- Start accepted in cycle T:
  - T+1 CLEAR (`core_rst`).
  - T+2 first RUN cycle (enable when PC < `prog_len`).
- Exit decided in RUN cycle E: DONE/`done` in E+1, IDLE and `load_ready` = 1 in E+2.
- A budget of N yields exactly N enable cycles (if no earlier halt/stop).
- A halt cycle is not counted and has enable = 0.
- Reset mid-run: immediate return to IDLE on the next edge. `prog_len` is cleared and a reload is required.

## Test plan
- Load 3 words with `load_last` on the 3rd, then start, bench PC model increments 0→3: `core_rst` high one cycle, enable for PC 0..2, `done` at PC=3 cycle+1, `cycles_run` = 3, `timed_out` = 0, `stopped` = 0.
- Same program, bench holds PC at 0 (loop), `budget` = 5: exactly 5 enable cycles, `done` pulse, `timed_out` = 1, `cycles_run` = 5.
- Loop with `budget` = 0, assert `stop` after 10 enabled cycles: `stopped` = 1, `cycles_run` = 11, `done` next cycle.
- Start with `prog_len` = 0, and start asserted mid-load (1 word accepted, no last): both ignored, state stays IDLE, `busy` = 0.
- `load_valid` and `start` high together in IDLE: word accepted, no CLEAR. Also stream 2**PC_WIDTH words without last: `prog_len` = 1024 (at default PC_WIDTH), `wptr` wraps to 0.
- `rst` pulsed during RUN: `global_enable` = 0 next cycle, state IDLE, `prog_len` = 0, subsequent start ignored until reload.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: loads a program, clears the core, then gates its execution until halt, budget or stop.
module run_sequencer #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 10,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CYCLE_WIDTH-1:0] budget,
  input  logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   core_rst,
  output logic                   global_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic                   stopped,
  output logic [CYCLE_WIDTH-1:0] cycles_run
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t state, state_next;
  logic [INSTR_WIDTH-1:0] mem [2**PC_WIDTH];
  logic [PC_WIDTH-1:0] wptr;
  logic [PC_WIDTH:0] prog_len;
  logic [CYCLE_WIDTH-1:0] budget_q, cycles_next;
  logic accept, last_word, start_ok, in_range, stop_hit, halt_hit, budget_hit;
  assign load_ready    = state == IDLE;
  assign accept        = load_valid && load_ready;
  assign last_word     = load_last || &wptr;
  // A load in the same cycle wins over start.
  assign start_ok      = start && load_ready && wptr == '0 && !accept && prog_len != '0;
  assign in_range      = {1'b0, program_counter} < prog_len;
  assign instruction   = in_range ? mem[program_counter] : '0;
  assign global_enable = state == RUN && in_range;
  assign cycles_next   = &cycles_run ? cycles_run : cycles_run + CYCLE_WIDTH'(1);
  assign stop_hit      = state == RUN && stop;
  assign halt_hit      = state == RUN && !in_range;
  assign budget_hit    = global_enable && budget_q != '0 && cycles_next == budget_q;
  assign busy          = state == CLEAR || state == RUN;
  assign done          = state == DONE;
  assign core_rst      = rst || state == CLEAR;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start_ok ? CLEAR : IDLE;
      CLEAR:   state_next = RUN;
      RUN:     state_next = (stop_hit || halt_hit || budget_hit) ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (accept) mem[wptr] <= load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      prog_len   <= '0;
      budget_q   <= '0;
      cycles_run <= '0;
      timed_out  <= 1'b0;
      stopped    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wptr <= last_word ? '0 : wptr + PC_WIDTH'(1);
        if (last_word) prog_len <= {1'b0, wptr} + (PC_WIDTH+1)'(1);
      end
      if (start_ok) begin
        budget_q   <= budget;
        cycles_run <= '0;
        timed_out  <= 1'b0;
        stopped    <= 1'b0;
      end
      if (global_enable) cycles_run <= cycles_next;
      if (stop_hit) stopped <= 1'b1;
      else if (budget_hit) timed_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed scenarios with a bench-side PC model and program shadow copy.
module tb_run_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic load_valid = 1'b0, load_ready, load_last = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] load_data = '0, budget = '0, instruction, cycles_run;
  logic [9:0] program_counter = '0;
  logic core_rst, global_enable, busy, done, timed_out, stopped;
  logic [31:0] exp_mem [1024];
  int vectors = 0, miscompares = 0;
  int en_cnt;
  bit got_done;
  run_sequencer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .stop(stop),
    .budget(budget), .program_counter(program_counter), .instruction(instruction),
    .core_rst(core_rst), .global_enable(global_enable), .busy(busy), .done(done),
    .timed_out(timed_out), .stopped(stopped), .cycles_run(cycles_run)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_word(input logic [9:0] addr, input logic [31:0] data, input logic last);
    load_valid = 1'b1; load_data = data; load_last = last; exp_mem[addr] = data;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask
  task automatic load3();
    load_word(10'd0, 32'hA000_0001, 1'b0);
    load_word(10'd1, 32'hB000_0002, 1'b0);
    load_word(10'd2, 32'hC000_0003, 1'b1);
  endtask
  task automatic do_start(input logic [31:0] b, input logic [9:0] pc);
    start = 1'b1; budget = b; program_counter = pc;
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_rst !== 1'b1 || global_enable !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_cycle: core_rst=%b en=%b busy=%b, required 1 0 1", core_rst, global_enable, busy);
    end
  endtask
  task automatic run(input bit inc, input int stop_after);
    bit en;
    en_cnt = 0; got_done = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1;
      else begin
        en = global_enable;
        if (en) begin
          en_cnt++;
          vectors++;
          if (instruction !== exp_mem[program_counter]) begin
            miscompares++;
            $display("FAIL fetch: pc=%0d got %h, required %h", program_counter, instruction, exp_mem[program_counter]);
          end
        end
        @(posedge clk);
        #1;
        if (en && inc) program_counter = program_counter + 10'd1;
        stop = stop_after > 0 && en_cnt == stop_after;
      end
    end
    stop = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL done_timeout: no done pulse within 200 cycles");
    end
  endtask
  task automatic check_end(input string name, input int en_exp, input logic [31:0] cyc_exp, input logic to_exp, input logic st_exp);
    vectors++;
    if (en_cnt != en_exp || cycles_run !== cyc_exp || timed_out !== to_exp || stopped !== st_exp) begin
      miscompares++;
      $display("FAIL %s: enables=%0d cycles=%0d to=%b stopped=%b, required %0d %0d %b %b",
               name, en_cnt, cycles_run, timed_out, stopped, en_exp, cyc_exp, to_exp, st_exp);
    end
    tick();
    vectors++;
    if (load_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: ready=%b done=%b busy=%b, required 1 0 0", name, load_ready, done, busy);
    end
  endtask
  task automatic test_reset();
    tick();
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_core_rst: got %b, required 1", core_rst);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (load_ready !== 1'b1 || global_enable !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 ||
        stopped !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b0 || cycles_run !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b en=%b done=%b to=%b st=%b busy=%b crst=%b cyc=%0d, required 1 0 0 0 0 0 0 0",
               load_ready, global_enable, done, timed_out, stopped, busy, core_rst, cycles_run);
    end
  endtask
  task automatic test_ignored_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_empty: busy=%b ready=%b, required 0 1", busy, load_ready);
    end
    load_word(10'd0, 32'h1111_1111, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || core_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL start_midload: busy=%b core_rst=%b, required 0 0", busy, core_rst);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_halt();
    load3();
    program_counter = 10'd1;
    @(negedge clk);
    vectors++;
    if (instruction !== 32'hB000_0002) begin
      miscompares++;
      $display("FAIL idle_read: got %h, required b0000002", instruction);
    end
    do_start(32'd0, 10'd0);
    run(1'b1, 0);
    check_end("halt", 3, 32'd3, 1'b0, 1'b0);
  endtask
  task automatic test_budget();
    do_start(32'd5, 10'd0);
    run(1'b0, 0);
    check_end("budget", 5, 32'd5, 1'b1, 1'b0);
  endtask
  task automatic test_stop();
    do_start(32'd0, 10'd0);
    run(1'b0, 10);
    check_end("stop", 11, 32'd11, 1'b0, 1'b1);
  endtask
  task automatic test_load_wins_and_full();
    load_valid = 1'b1; load_data = 32'h5000_0000; load_last = 1'b0; start = 1'b1;
    exp_mem[0] = 32'h5000_0000;
    tick();
    load_valid = 1'b0; start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || core_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL load_vs_start: busy=%b core_rst=%b, required 0 0", busy, core_rst);
    end
    for (int i = 1; i < 1024; i++) load_word(10'(i), 32'h5000_0000 | i, 1'b0);
    program_counter = 10'd1023;
    @(negedge clk);
    vectors++;
    if (instruction !== 32'h5000_03FF) begin
      miscompares++;
      $display("FAIL full_len: pc 1023 got %h, required 500003ff", instruction);
    end
    do_start(32'd2, 10'd1023);
    run(1'b0, 0);
    check_end("full_budget", 2, 32'd2, 1'b1, 1'b0);
  endtask
  task automatic test_rst_in_run();
    do_start(32'd0, 10'd0);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_core: got %b, required 1", core_rst);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (global_enable !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || cycles_run !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_run: en=%b busy=%b ready=%b cyc=%0d, required 0 0 1 0", global_enable, busy, load_ready, cycles_run);
    end
    vectors++;
    if (instruction !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_len: pc0 instruction %h, required 0", instruction);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_start: busy=%b, required 0", busy);
    end
  endtask
  task automatic test_back_to_back();
    load3();
    do_start(32'd0, 10'd0);
    run(1'b1, 0);
    check_end("reload_halt", 3, 32'd3, 1'b0, 1'b0);
    do_start(32'd2, 10'd0);
    run(1'b1, 0);
    check_end("rerun_budget", 2, 32'd2, 1'b1, 1'b0);
  endtask
  initial begin
    test_reset();
    test_ignored_start();
    test_halt();
    test_budget();
    test_stop();
    test_load_wins_and_full();
    test_rst_in_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
